i3c_bus_phy: RTL and testbench
==============================

Name: i3c_bus_phy

Overview:
Parametrised successor to the I3C bus controller. It is a command-driven SCL/SDA bit engine with separate open-drain and push-pull timing, and a valid/ready command interface. The engine generates START, repeated START, write-bit, read-bit and STOP. It returns per-command responses with read data and open-drain arbitration-loss detection. It sits between the protocol FSM (upstream) and the pad drivers (scl_o/sda_o/sel_od_pp_o).

Parameters:
DIV_W, 16, phase counter width; every *_CNT must be in 1..2^DIV_W-1
OD_LO_CNT, 50, SCL low phase length in clk_i cycles, open-drain bits and conditions
OD_HI_CNT, 50, SCL high phase length, open-drain; also START hold and STOP setup
PP_LO_CNT, 4, SCL low phase length, push-pull bits
PP_HI_CNT, 4, SCL high phase length, push-pull bits
BUF_CNT, 130, bus-free time after STOP before returning to IDLE

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&&ready
cmd_i  in  3  START=0, RSTART=1, WRITE=2, READ=3, STOP=4 (5-7 illegal)
cmd_od_i  in  1  1=open-drain timing/drive, 0=push-pull (WRITE/READ only)
cmd_bit_i  in  1  write data bit
rsp_valid_o  out  1  one-cycle pulse on command completion
rsp_bit_o  out  1  sampled sda_i (READ/WRITE), else 0
rsp_arb_lost_o  out  1  arbitration lost on this bit
rsp_err_o  out  1  illegal command for current state
busy_o  out  1  state != IDLE
scl_i  in  1  bus SCL sense (unused except reserved)
sda_i  in  1  bus SDA sense
scl_o  out  1  SCL drive
sda_o  out  1  SDA drive (1 = released in open-drain)
sel_od_pp_o  out  1  1=push-pull, 0=open-drain

Behaviour:
- Clock and reset: one clock clk_i. Reset rst_i is synchronous, active-high. All outputs are registered.
- Reset values: state=IDLE, scl_o=1, sda_o=1, sel_od_pp_o=0, rsp_*=0, busy_o=0. cmd_ready_o=1 once reset deasserts.
- Reset mid-operation: next cycle scl_o=sda_o=1 and state=IDLE. No STOP is generated and no rsp is emitted.
- States: IDLE, START_HD, HOLD, BIT_LO, BIT_HI, RS_LO, RS_HI, STOP_LO, STOP_HI, STOP_BUF.
- Phase counter: a phase of length N occupies exactly N cycles. The counter loads N-1 on entry and the state advances when it reaches 0.
- cmd_ready_o=1 only in IDLE and HOLD. A command is accepted on the edge where valid&&ready. The new state and outputs take effect the next cycle.
- IDLE (scl=1, sda=1):
  - START -> START_HD: sda_o=0, scl_o=1 for OD_HI_CNT cycles, then HOLD with scl_o=0; rsp pulses on entry to HOLD.
  - Any other command -> rsp_valid_o=1, rsp_err_o=1 next cycle; no bus activity.
- HOLD: scl_o=0, sda_o holds its last value, sel_od_pp_o=0.
  - START or RSTART -> RS_LO: sda_o=1, OD_LO_CNT cycles. Then RS_HI: scl_o=1, OD_HI_CNT cycles. Then START_HD.
  - WRITE -> BIT_LO: scl_o=0, sda_o=cmd_bit_i from the first cycle, LO_CNT cycles. Then BIT_HI: scl_o=1, HI_CNT cycles. Then HOLD.
  - READ: same sequence as WRITE, with sda_o=1.
  - STOP -> STOP_LO: sda_o=0, OD_LO_CNT cycles. Then STOP_HI: scl_o=1, OD_HI_CNT cycles. Then STOP_BUF: sda_o=1, BUF_CNT cycles. Then IDLE; rsp pulses on entry to IDLE.
  - Illegal codes 5-7 -> rsp_err_o pulse; state unchanged.
- Bit timing: LO_CNT/HI_CNT are the OD_* or PP_* values selected by cmd_od_i, latched at accept.
- Drive mode: sel_od_pp_o=1 only in BIT_LO/BIT_HI of a WRITE with cmd_od_i=0. Otherwise 0.
- Sampling: sda_i is sampled on the last BIT_HI cycle into rsp_bit_o.
- Arbitration: in an open-drain WRITE with bit=1, a sampled sda_i=0 sets rsp_arb_lost_o=1. The engine still completes to HOLD with sda_o=1.
- rsp_valid_o pulses on the cycle the state re-enters HOLD or IDLE, which is also the first cycle cmd_ready_o=1 again. A new command may be accepted on that same cycle.
- rsp fields are valid only while rsp_valid_o=1 and are 0 otherwise.

Decomposition:
- i3c_params.vh gains: command encodings (CMD_START..CMD_STOP), PHY state encodings, and default timing constants.
- One sub-module, i3c_phase_timer: DIV_W down-counter with load value, load strobe and done flag. It is reused for all phases.

Test Plan:
- Reset: assert rst_i for 3 cycles mid-BIT_HI -> next cycle scl_o=1, sda_o=1, sel_od_pp_o=0, busy_o=0, no rsp_valid_o.
- START then PP WRITE bit=1 (defaults) -> START_HD lasts 50 cycles with sda_o=0, scl_o=1. WRITE accepted at cycle t: scl_o=0 and sda_o=1 and sel_od_pp_o=1 for t+1..t+4; scl_o=1 for t+5..t+8; rsp_valid_o at t+9.
- OD READ with bus forcing sda_i=0 -> 50 cycles low, 50 high, sda_o=1, sel_od_pp_o=0; rsp_bit_o=0, rsp_arb_lost_o=0.
- OD WRITE bit=1 with sda_i forced 0 -> rsp_arb_lost_o=1, rsp_bit_o=0, final sda_o=1, state HOLD.
- START in HOLD -> repeated START: sda rises while scl is low, scl rises, sda falls while scl is high; exactly one rsp.
- STOP then WRITE in IDLE -> STOP: sda rises while scl is high, busy_o stays 1 for BUF_CNT=130 more cycles. WRITE in IDLE gives rsp_err_o=1 and scl_o/sda_o stay 1.

Source files
------------

// File: rtl/i3c_bus_phy_pkg.sv
// i3c_bus_phy_pkg: shared definitions for the I3C SCL/SDA bit engine.
//   cmd_e       - command encodings presented on cmd_i
//   phy_state_e - bit-engine state encodings
//   DEF_*_CNT   - default phase lengths in clk_i cycles
package i3c_bus_phy_pkg;

  typedef enum logic [2:0] {
    CMD_START  = 3'd0,
    CMD_RSTART = 3'd1,
    CMD_WRITE  = 3'd2,
    CMD_READ   = 3'd3,
    CMD_STOP   = 3'd4
  } cmd_e;

  typedef enum logic [3:0] {
    PHY_IDLE,
    PHY_START_HD,
    PHY_HOLD,
    PHY_BIT_LO,
    PHY_BIT_HI,
    PHY_RS_LO,
    PHY_RS_HI,
    PHY_STOP_LO,
    PHY_STOP_HI,
    PHY_STOP_BUF
  } phy_state_e;

  localparam int unsigned DEF_DIV_W     = 16;
  localparam int unsigned DEF_OD_LO_CNT = 50;
  localparam int unsigned DEF_OD_HI_CNT = 50;
  localparam int unsigned DEF_PP_LO_CNT = 4;
  localparam int unsigned DEF_PP_HI_CNT = 4;
  localparam int unsigned DEF_BUF_CNT   = 130;

endpackage

// File: rtl/i3c_phase_timer.sv
// i3c_phase_timer: down-counter shared by every timed bus phase.
//   clk_i, rst_i  - clock, synchronous active-high reset
//   load_i        - load load_val_i (phase length minus one)
//   load_val_i    - value loaded on load_i
//   done_o        - counter is at zero (last cycle of the phase)
module i3c_phase_timer #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic             done_o
);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/i3c_bus_phy.sv
// i3c_bus_phy: command-driven I3C SCL/SDA bit engine.
//   clk_i, rst_i        - clock, synchronous active-high reset
//   cmd_valid_i/ready_o - command handshake; cmd_i/cmd_od_i/cmd_bit_i payload
//   rsp_*_o             - one-cycle completion response (bit, arb loss, error)
//   busy_o              - engine not idle
//   scl_i, sda_i        - bus sense (scl_i reserved)
//   scl_o, sda_o        - pad drive; sel_od_pp_o 1 = push-pull, 0 = open-drain
module i3c_bus_phy
  import i3c_bus_phy_pkg::*;
#(
  parameter int unsigned DIV_W     = DEF_DIV_W,
  parameter int unsigned OD_LO_CNT = DEF_OD_LO_CNT,
  parameter int unsigned OD_HI_CNT = DEF_OD_HI_CNT,
  parameter int unsigned PP_LO_CNT = DEF_PP_LO_CNT,
  parameter int unsigned PP_HI_CNT = DEF_PP_HI_CNT,
  parameter int unsigned BUF_CNT   = DEF_BUF_CNT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [2:0] cmd_i,
  input  logic       cmd_od_i,
  input  logic       cmd_bit_i,
  output logic       rsp_valid_o,
  output logic       rsp_bit_o,
  output logic       rsp_arb_lost_o,
  output logic       rsp_err_o,
  output logic       busy_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       sel_od_pp_o
);

  localparam logic [DIV_W-1:0] OD_LO_M1 = DIV_W'(OD_LO_CNT - 1);
  localparam logic [DIV_W-1:0] OD_HI_M1 = DIV_W'(OD_HI_CNT - 1);
  localparam logic [DIV_W-1:0] PP_LO_M1 = DIV_W'(PP_LO_CNT - 1);
  localparam logic [DIV_W-1:0] PP_HI_M1 = DIV_W'(PP_HI_CNT - 1);
  localparam logic [DIV_W-1:0] BUF_M1   = DIV_W'(BUF_CNT - 1);

  phy_state_e       state_q, state_d;
  logic [DIV_W-1:0] hi_m1_q;
  logic [DIV_W-1:0] load_val;
  logic             tmr_load, tmr_done;
  logic             accept, illegal;
  logic             op_write_q, op_od_q, op_bit_q;
  logic             scl_unused;

  assign scl_unused = scl_i;
  assign accept     = cmd_valid_i && cmd_ready_o;

  // Next state and the length of the phase being entered. Every timed
  // phase is a distinct state, so a state change is the timer load strobe.
  always_comb begin
    state_d  = state_q;
    load_val = '0;
    illegal  = 1'b0;
    case (state_q)
      PHY_IDLE: begin
        if (accept) begin
          if (cmd_i == CMD_START) begin
            state_d  = PHY_START_HD;
            load_val = OD_HI_M1;
          end else begin
            illegal = 1'b1;
          end
        end
      end
      PHY_HOLD: begin
        if (accept) begin
          case (cmd_i)
            CMD_START, CMD_RSTART: begin
              state_d  = PHY_RS_LO;
              load_val = OD_LO_M1;
            end
            CMD_WRITE, CMD_READ: begin
              state_d  = PHY_BIT_LO;
              load_val = cmd_od_i ? OD_LO_M1 : PP_LO_M1;
            end
            CMD_STOP: begin
              state_d  = PHY_STOP_LO;
              load_val = OD_LO_M1;
            end
            default: illegal = 1'b1;
          endcase
        end
      end
      PHY_START_HD: if (tmr_done) state_d = PHY_HOLD;
      PHY_RS_LO: begin
        if (tmr_done) begin
          state_d  = PHY_RS_HI;
          load_val = OD_HI_M1;
        end
      end
      PHY_RS_HI: begin
        if (tmr_done) begin
          state_d  = PHY_START_HD;
          load_val = OD_HI_M1;
        end
      end
      PHY_BIT_LO: begin
        if (tmr_done) begin
          state_d  = PHY_BIT_HI;
          load_val = hi_m1_q;
        end
      end
      PHY_BIT_HI: if (tmr_done) state_d = PHY_HOLD;
      PHY_STOP_LO: begin
        if (tmr_done) begin
          state_d  = PHY_STOP_HI;
          load_val = OD_HI_M1;
        end
      end
      PHY_STOP_HI: begin
        if (tmr_done) begin
          state_d  = PHY_STOP_BUF;
          load_val = BUF_M1;
        end
      end
      PHY_STOP_BUF: if (tmr_done) state_d = PHY_IDLE;
      default: state_d = PHY_IDLE;
    endcase
  end

  assign tmr_load = (state_d != state_q);

  i3c_phase_timer #(
    .DIV_W(DIV_W)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (tmr_load),
    .load_val_i(load_val),
    .done_o    (tmr_done)
  );

  // Outputs are registered against the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= PHY_IDLE;
      scl_o          <= 1'b1;
      sda_o          <= 1'b1;
      sel_od_pp_o    <= 1'b0;
      rsp_valid_o    <= 1'b0;
      rsp_bit_o      <= 1'b0;
      rsp_arb_lost_o <= 1'b0;
      rsp_err_o      <= 1'b0;
      busy_o         <= 1'b0;
      cmd_ready_o    <= 1'b1;
      hi_m1_q        <= '0;
      op_write_q     <= 1'b0;
      op_od_q        <= 1'b0;
      op_bit_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_o         <= (state_d != PHY_IDLE);
      cmd_ready_o    <= (state_d == PHY_IDLE) || (state_d == PHY_HOLD);
      rsp_valid_o    <= 1'b0;
      rsp_bit_o      <= 1'b0;
      rsp_arb_lost_o <= 1'b0;
      rsp_err_o      <= 1'b0;

      if (illegal) begin
        rsp_valid_o <= 1'b1;
        rsp_err_o   <= 1'b1;
      end

      if (accept && (state_q == PHY_HOLD)) begin
        op_write_q <= (cmd_i == CMD_WRITE);
        op_od_q    <= cmd_od_i;
        op_bit_q   <= cmd_bit_i;
        hi_m1_q    <= cmd_od_i ? OD_HI_M1 : PP_HI_M1;
      end

      if (state_d != state_q) begin
        case (state_d)
          PHY_IDLE: begin
            scl_o       <= 1'b1;
            sda_o       <= 1'b1;
            sel_od_pp_o <= 1'b0;
            rsp_valid_o <= 1'b1;
          end
          PHY_START_HD: begin
            scl_o       <= 1'b1;
            sda_o       <= 1'b0;
            sel_od_pp_o <= 1'b0;
          end
          PHY_HOLD: begin
            scl_o       <= 1'b0;
            sel_od_pp_o <= 1'b0;
            rsp_valid_o <= 1'b1;
            if (state_q == PHY_BIT_HI) begin
              rsp_bit_o      <= sda_i;
              rsp_arb_lost_o <= op_od_q && op_write_q && op_bit_q && !sda_i;
            end
          end
          PHY_BIT_LO: begin
            scl_o       <= 1'b0;
            sda_o       <= (cmd_i == CMD_WRITE) ? cmd_bit_i : 1'b1;
            sel_od_pp_o <= (cmd_i == CMD_WRITE) && !cmd_od_i;
          end
          PHY_BIT_HI:   scl_o <= 1'b1;
          PHY_RS_LO: begin
            scl_o       <= 1'b0;
            sda_o       <= 1'b1;
            sel_od_pp_o <= 1'b0;
          end
          PHY_RS_HI:    scl_o <= 1'b1;
          PHY_STOP_LO: begin
            scl_o       <= 1'b0;
            sda_o       <= 1'b0;
            sel_od_pp_o <= 1'b0;
          end
          PHY_STOP_HI:  scl_o <= 1'b1;
          PHY_STOP_BUF: sda_o <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i3c_bus_phy.sv
// tb_i3c_bus_phy: directed, table-driven bench for i3c_bus_phy with default
// timing (OD 50/50, PP 4/4, BUF 130). Rows run back to back, so each row
// starts in the state the previous row left behind.
module tb_i3c_bus_phy;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [2:0] cmd_i;
  logic       cmd_od_i;
  logic       cmd_bit_i;
  logic       rsp_valid_o;
  logic       rsp_bit_o;
  logic       rsp_arb_lost_o;
  logic       rsp_err_o;
  logic       busy_o;
  logic       scl_i;
  logic       sda_i;
  logic       scl_o;
  logic       sda_o;
  logic       sel_od_pp_o;

  always #5 clk_i = ~clk_i;

  i3c_bus_phy dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_i         (cmd_i),
    .cmd_od_i      (cmd_od_i),
    .cmd_bit_i     (cmd_bit_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_bit_o     (rsp_bit_o),
    .rsp_arb_lost_o(rsp_arb_lost_o),
    .rsp_err_o     (rsp_err_o),
    .busy_o        (busy_o),
    .scl_i         (scl_i),
    .sda_i         (sda_i),
    .scl_o         (scl_o),
    .sda_o         (sda_o),
    .sel_od_pp_o   (sel_od_pp_o)
  );

  // lat: cycles from accept edge to rsp cycle; counts/firsts cover cycles
  // strictly before the rsp cycle (-1 = never seen); busy/scl/sda at rsp.
  typedef struct {
    int cmd; int od; int wb; int bus;
    int lat; int rb; int arb; int err;
    int scl_lo; int sel_hi; int sda_lo; int fsh; int fsl;
    int busy; int scl; int sda;
  } vec_t;

  vec_t vecs[16];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_cmd(input logic [2:0] c, input logic od, input logic b,
                         output int lat, output int rb, output int arb,
                         output int err, output int scl_lo, output int sel_hi,
                         output int sda_lo, output int fsh, output int fsl);
    int guard = 0;
    while (!cmd_ready_o && guard < 2000) begin
      @(negedge clk_i);
      guard++;
    end
    if (!cmd_ready_o) chk("ready_wait", 0, 1);
    cmd_i = c; cmd_od_i = od; cmd_bit_i = b; cmd_valid_i = 1'b1;
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
    lat = 0; scl_lo = 0; sel_hi = 0; sda_lo = 0; fsh = -1; fsl = -1;
    rb = 0; arb = 0; err = 0;
    while (lat < 400) begin
      @(negedge clk_i);
      lat++;
      if (rsp_valid_o) break;
      if (!scl_o) scl_lo++;
      if (sel_od_pp_o) sel_hi++;
      if (!sda_o) sda_lo++;
      if (scl_o && fsh < 0) fsh = lat;
      if (!sda_o && fsl < 0) fsl = lat;
    end
    if (!rsp_valid_o) chk("rsp_timeout", 0, 1);
    rb = int'(rsp_bit_o); arb = int'(rsp_arb_lost_o); err = int'(rsp_err_o);
  endtask

  initial begin
    int lat, rb, arb, err, scl_lo, sel_hi, sda_lo, fsh, fsl, seen;
    //        cmd od wb bus  lat rb arb err  sclL sel sdaL fsh  fsl  busy scl sda
    vecs = '{
      '{2, 0, 1, 1,    1, 0, 0, 1,    0, 0,   0,  -1,  -1,  0, 1, 1},  // WRITE in IDLE
      '{4, 0, 0, 1,    1, 0, 0, 1,    0, 0,   0,  -1,  -1,  0, 1, 1},  // STOP in IDLE
      '{6, 0, 0, 1,    1, 0, 0, 1,    0, 0,   0,  -1,  -1,  0, 1, 1},  // code 6 in IDLE
      '{0, 0, 0, 1,   51, 0, 0, 0,    0, 0,  50,   1,   1,  1, 0, 0},  // START
      '{2, 0, 1, 1,    9, 1, 0, 0,    4, 8,   0,   5,  -1,  1, 0, 1},  // PP WRITE 1
      '{3, 1, 0, 0,  101, 0, 0, 0,   50, 0,   0,  51,  -1,  1, 0, 1},  // OD READ, bus 0
      '{2, 1, 1, 0,  101, 0, 1, 0,   50, 0,   0,  51,  -1,  1, 0, 1},  // OD WRITE 1, arb lost
      '{2, 1, 0, 0,  101, 0, 0, 0,   50, 0, 100,  51,   1,  1, 0, 0},  // OD WRITE 0
      '{1, 1, 0, 1,  151, 0, 0, 0,   50, 0,  50,  51, 101,  1, 0, 0},  // RSTART
      '{7, 0, 0, 1,    1, 0, 0, 1,    0, 0,   0,  -1,  -1,  1, 0, 0},  // code 7 in HOLD
      '{2, 0, 0, 0,    9, 0, 0, 0,    4, 8,   8,   5,   1,  1, 0, 0},  // PP WRITE 0
      '{2, 0, 1, 0,    9, 0, 0, 0,    4, 8,   0,   5,  -1,  1, 0, 1},  // PP WRITE 1, no arb
      '{0, 0, 0, 1,  151, 0, 0, 0,   50, 0,  50,  51, 101,  1, 0, 0},  // START in HOLD
      '{3, 0, 0, 1,    9, 1, 0, 0,    4, 0,   0,   5,  -1,  1, 0, 1},  // PP READ, bus 1
      '{4, 0, 0, 1,  231, 0, 0, 0,   50, 0, 100,  51,   1,  0, 1, 1},  // STOP
      '{3, 0, 0, 1,    1, 0, 0, 1,    0, 0,   0,  -1,  -1,  0, 1, 1}   // READ in IDLE
    };

    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_i = '0; cmd_od_i = 1'b0;
    cmd_bit_i = 1'b0; scl_i = 1'b1; sda_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst.scl", scl_o, 1);
    chk("rst.sda", sda_o, 1);
    chk("rst.sel", sel_od_pp_o, 0);
    chk("rst.rsp", {rsp_valid_o, rsp_bit_o, rsp_arb_lost_o, rsp_err_o}, 0);
    chk("rst.busy", busy_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst.ready", cmd_ready_o, 1);

    for (int i = 0; i < 16; i++) begin
      sda_i = 1'(vecs[i].bus);
      run_cmd(3'(vecs[i].cmd), 1'(vecs[i].od), 1'(vecs[i].wb),
              lat, rb, arb, err, scl_lo, sel_hi, sda_lo, fsh, fsl);
      chk($sformatf("v%0d.lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d.rsp_bit", i), rb, vecs[i].rb);
      chk($sformatf("v%0d.arb", i), arb, vecs[i].arb);
      chk($sformatf("v%0d.err", i), err, vecs[i].err);
      chk($sformatf("v%0d.scl_lo", i), scl_lo, vecs[i].scl_lo);
      chk($sformatf("v%0d.sel_hi", i), sel_hi, vecs[i].sel_hi);
      chk($sformatf("v%0d.sda_lo", i), sda_lo, vecs[i].sda_lo);
      chk($sformatf("v%0d.first_scl_hi", i), fsh, vecs[i].fsh);
      chk($sformatf("v%0d.first_sda_lo", i), fsl, vecs[i].fsl);
      chk($sformatf("v%0d.busy", i), busy_o, vecs[i].busy);
      chk($sformatf("v%0d.scl", i), scl_o, vecs[i].scl);
      chk($sformatf("v%0d.sda", i), sda_o, vecs[i].sda);
      chk($sformatf("v%0d.sel", i), sel_od_pp_o, 0);
      chk($sformatf("v%0d.ready", i), cmd_ready_o, 1);
      @(negedge clk_i);
      chk($sformatf("v%0d.pulse", i),
          {rsp_valid_o, rsp_bit_o, rsp_arb_lost_o, rsp_err_o}, 0);
    end

    // Reset in the middle of a push-pull write's high phase.
    sda_i = 1'b1;
    run_cmd(3'd0, 1'b0, 1'b0, lat, rb, arb, err, scl_lo, sel_hi, sda_lo, fsh, fsl);
    chk("mid.start_lat", lat, 51);
    @(negedge clk_i);
    cmd_i = 3'd2; cmd_od_i = 1'b0; cmd_bit_i = 1'b1; cmd_valid_i = 1'b1;
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
    repeat (6) @(negedge clk_i);
    chk("mid.scl", scl_o, 1);
    chk("mid.sel", sel_od_pp_o, 1);
    rst_i = 1'b1;
    seen = 0;
    @(negedge clk_i);
    if (rsp_valid_o) seen++;
    chk("mrst.scl", scl_o, 1);
    chk("mrst.sda", sda_o, 1);
    chk("mrst.sel", sel_od_pp_o, 0);
    chk("mrst.busy", busy_o, 0);
    repeat (2) begin
      @(negedge clk_i);
      if (rsp_valid_o) seen++;
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    if (rsp_valid_o) seen++;
    chk("mrst.no_rsp", seen, 0);
    chk("mrst.ready", cmd_ready_o, 1);
    chk("mrst.idle_busy", busy_o, 0);
    chk("mrst.idle_scl", scl_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
